// File: rtl/addsub_seq_ctrl.sv
// Two-requester, round-robin arbitrated 16-bit add/subtract unit.
// The operation is computed serially, one 4-bit nibble per cycle, LSB nibble first.
module addsub_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [15:0] a0,
  input  logic [15:0] b0,
  input  logic        sub0,
  input  logic        req1,
  input  logic [15:0] a1,
  input  logic [15:0] b1,
  input  logic        sub1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        busy,
  output logic        done,
  output logic        done_id,
  output logic [15:0] result,
  output logic        cout,
  output logic        ovfl
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q,   state_d;
  logic        last_q,    last_d;
  logic [15:0] a_q,       a_d;
  logic [15:0] b_q,       b_d;
  logic        sub_q,     sub_d;
  logic        id_q,      id_d;
  logic [1:0]  cnt_q,     cnt_d;
  logic        carry_q,   carry_d;
  logic [15:0] result_q,  result_d;
  logic        cout_q,    cout_d;
  logic        ovfl_q,    ovfl_d;
  logic        done_q,    done_d;
  logic        done_id_q, done_id_d;
  logic        busy_q,    busy_d;

  // Round-robin arbiter: requester 1 wins alone, or when both request and 0 went last.
  logic any_req;
  logic pick1;
  logic idle;

  assign any_req = req0 | req1;
  assign pick1   = req1 & (~req0 | ~last_q);
  assign idle    = (state_q == IDLE);
  assign gnt0    = idle & any_req & ~pick1;
  assign gnt1    = idle & pick1;

  // Nibble datapath; the 3-bit partial sum exposes the carry into the top bit for overflow.
  logic [3:0] a_nib;
  logic [3:0] b_nib_x;
  logic [3:0] lo_sum;
  logic [4:0] nib_sum;

  always_comb begin
    a_nib   = a_q[{cnt_q, 2'b00} +: 4];
    b_nib_x = b_q[{cnt_q, 2'b00} +: 4] ^ {4{sub_q}};
    lo_sum  = {1'b0, a_nib[2:0]} + {1'b0, b_nib_x[2:0]} + {3'b000, carry_q};
    nib_sum = {1'b0, a_nib} + {1'b0, b_nib_x} + {4'b0000, carry_q};
  end

  always_comb begin
    // NOTE: every _d starts as its _q so no path through this block can infer a latch.
    state_d   = state_q;
    last_d    = last_q;
    a_d       = a_q;
    b_d       = b_q;
    sub_d     = sub_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    result_d  = result_q;
    cout_d    = cout_q;
    ovfl_d    = ovfl_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    busy_d    = busy_q;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          a_d     = pick1 ? a1 : a0;
          b_d     = pick1 ? b1 : b0;
          sub_d   = pick1 ? sub1 : sub0;
          carry_d = pick1 ? sub1 : sub0;
          id_d    = pick1;
          last_d  = pick1;
          cnt_d   = 2'd0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        result_d[{cnt_q, 2'b00} +: 4] = nib_sum[3:0];
        carry_d = nib_sum[4];
        cnt_d   = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          cout_d    = nib_sum[4];
          ovfl_d    = lo_sum[3] ^ nib_sum[4];
          done_d    = 1'b1;
          done_id_d = id_q;
          state_d   = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: the captured operand registers are reset too, so no X ever reaches the datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= 1'b0;
      id_q      <= 1'b0;
      cnt_q     <= 2'd0;
      carry_q   <= 1'b0;
      result_q  <= '0;
      cout_q    <= 1'b0;
      ovfl_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking updates keep every flop sampling pre-edge values.
      state_q   <= state_d;
      last_q    <= last_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sub_q     <= sub_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      result_q  <= result_d;
      cout_q    <= cout_d;
      ovfl_q    <= ovfl_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      busy_q    <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign result  = result_q;
  assign cout    = cout_q;
  assign ovfl    = ovfl_q;

endmodule
